// File: rtl/stream_mux_n_if.sv
// Stream bundle between N producers, the multiplexer and one consumer.
// The multiplexer connects through the slave modport; the driving side uses master.
interface stream_mux_n_if #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
);
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic [SELW-1:0]    sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_ch;
  logic               out_ready;

  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/stream_mux_n.sv
// N-channel registered stream multiplexer with external-select or round-robin
// arbitration feeding a single output register that sustains one word per cycle.
module stream_mux_n #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int MODE  = 1
) (
  input logic           clk,
  input logic           rst_n,
  stream_mux_n_if.slave bus
);

  localparam int SELW = $clog2(N);

  logic [SELW-1:0]  ptr;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_ch_q;

  logic [WIDTH-1:0] words [N];
  logic             rr_found;
  logic [SELW-1:0]  rr_idx;
  logic [SELW-1:0]  rr_cand;
  int               rr_pos;
  logic             sel_found;
  logic             grant_found;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_word;
  logic             space;
  logic             take;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      words[i] = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin search starting at ptr and wrapping past N-1 back to 0.
  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    rr_pos   = 0;
    for (int k = 0; k < N; k++) begin
      rr_pos = int'(ptr) + k;
      if (rr_pos >= N) rr_pos = rr_pos - N;
      rr_cand = SELW'(rr_pos);
      if (!rr_found && bus.in_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // An out-of-range select never grants, which matters only when N is not a power of two.
  always_comb begin
    sel_found = 1'b0;
    if (int'(bus.sel) < N) sel_found = bus.in_valid[bus.sel];
  end

  assign grant_found = (MODE == 1) ? rr_found : sel_found;
  assign grant_idx   = (MODE == 1) ? rr_idx   : bus.sel;
  assign grant_word  = words[grant_idx];

  assign space = !out_valid_q || bus.out_ready;
  assign take  = grant_found && space;

  // Ready depends only on the granted channel and output space; held low in reset.
  always_comb begin
    bus.in_ready = '0;
    if (rst_n && take) bus.in_ready[grant_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr         <= '0;
    end else if (take) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_word;
      out_ch_q    <= grant_idx;
      if (MODE == 1) begin
        ptr <= (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.in_ready));

  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_ch_q)));

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: one select-mode and one round-robin instance share stimulus;
// each is compared cycle by cycle with a rule-level model and a per-channel scoreboard.
module tb_stream_mux_n;

  localparam int WIDTH = 64;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]       drv_valid;
  logic [WIDTH-1:0]   drv_data [N];
  logic [N*WIDTH-1:0] drv_packed;
  logic [SELW-1:0]    drv_sel;
  logic               drv_ready;

  stream_mux_n_if #(.WIDTH(WIDTH), .N(N)) if0 ();
  stream_mux_n_if #(.WIDTH(WIDTH), .N(N)) if1 ();

  stream_mux_n #(.WIDTH(WIDTH), .N(N), .MODE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  stream_mux_n #(.WIDTH(WIDTH), .N(N), .MODE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  always #5 clk = ~clk;

  always_comb begin
    drv_packed = '0;
    for (int i = 0; i < N; i++) drv_packed[i*WIDTH +: WIDTH] = drv_data[i];
  end

  assign if0.in_valid  = drv_valid;
  assign if0.in_data   = drv_packed;
  assign if0.sel       = drv_sel;
  assign if0.out_ready = drv_ready;
  assign if1.in_valid  = drv_valid;
  assign if1.in_data   = drv_packed;
  assign if1.sel       = drv_sel;
  assign if1.out_ready = drv_ready;

  logic [N-1:0]     obs_ir  [2];
  logic             obs_ov  [2];
  logic [WIDTH-1:0] obs_od  [2];
  logic [SELW-1:0]  obs_och [2];

  assign obs_ir[0]  = if0.in_ready;
  assign obs_ov[0]  = if0.out_valid;
  assign obs_od[0]  = if0.out_data;
  assign obs_och[0] = if0.out_ch;
  assign obs_ir[1]  = if1.in_ready;
  assign obs_ov[1]  = if1.out_valid;
  assign obs_od[1]  = if1.out_data;
  assign obs_och[1] = if1.out_ch;

  // Model of each instance: index 0 is select mode, index 1 is round-robin.
  logic             m_valid [2];
  logic [WIDTH-1:0] m_data  [2];
  int               m_ch    [2];
  int               m_ptr   [2];
  logic [WIDTH-1:0] sbq [2][N][$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int exp_grant(int d);
    if (m_valid[d] && !drv_ready) return -1;
    if (d == 0) begin
      if (int'(drv_sel) < N && drv_valid[drv_sel]) return int'(drv_sel);
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      if (drv_valid[(m_ptr[d] + k) % N]) return (m_ptr[d] + k) % N;
    end
    return -1;
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = '0;
      m_ch[d]    = 0;
      m_ptr[d]   = 0;
      for (int i = 0; i < N; i++) sbq[d][i].delete();
    end
  endtask

  task automatic new_data();
    for (int i = 0; i < N; i++) drv_data[i] = {$urandom, $urandom};
  endtask

  // One clock: compare pre-edge state with the model, log handshakes, advance the model.
  task automatic run_cycle();
    int               g [2];
    logic [N-1:0]     exp_ir;
    logic [WIDTH-1:0] exp_word;
    int               ch;
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d]   = exp_grant(d);
      exp_ir = '0;
      if (g[d] >= 0) exp_ir[g[d]] = 1'b1;
      n_checks++;
      if (obs_ir[d] !== exp_ir) begin
        n_fail++;
        $display("FAIL in_ready[dut%0d]: got %b expected %b (test fail)", d, obs_ir[d], exp_ir);
      end
      n_checks++;
      if (obs_ov[d] !== m_valid[d]) begin
        n_fail++;
        $display("FAIL out_valid[dut%0d]: got %b expected %b (test fail)", d, obs_ov[d], m_valid[d]);
      end
      if (m_valid[d]) begin
        n_checks++;
        if (obs_od[d] !== m_data[d] || int'(obs_och[d]) != m_ch[d]) begin
          n_fail++;
          $display("FAIL out_word[dut%0d]: got ch%0d %h expected ch%0d %h (test fail)",
                   d, obs_och[d], obs_od[d], m_ch[d], m_data[d]);
        end
      end
      if (obs_ov[d] === 1'b1 && drv_ready) begin
        ch = int'(obs_och[d]);
        n_checks++;
        if (sbq[d][ch].size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard[dut%0d]: got ch%0d %h expected no pending word (test fail)",
                   d, ch, obs_od[d]);
        end else begin
          exp_word = sbq[d][ch].pop_front();
          if (obs_od[d] !== exp_word) begin
            n_fail++;
            $display("FAIL scoreboard[dut%0d]: got ch%0d %h expected %h (test fail)",
                     d, ch, obs_od[d], exp_word);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (drv_valid[i] && obs_ir[d][i] === 1'b1) sbq[d][i].push_back(drv_data[i]);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (g[d] >= 0) begin
        m_valid[d] = 1'b1;
        m_data[d]  = drv_data[g[d]];
        m_ch[d]    = g[d];
        if (d == 1) m_ptr[d] = (g[d] + 1) % N;
      end else if (m_valid[d] && drv_ready) begin
        m_valid[d] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    drv_valid = '0;
    rst_n     = 1'b0;
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Before any clock edge, then asserted asynchronously in the middle of a stream.
    drv_valid = '1;
    drv_ready = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_ov[d] !== 1'b0 || obs_od[d] !== '0 || obs_och[d] !== '0 || obs_ir[d] !== '0) begin
        n_fail++;
        $display("FAIL reset_initial[dut%0d]: got v=%b d=%h ch=%0d rdy=%b expected all zero (test fail)",
                 d, obs_ov[d], obs_od[d], obs_och[d], obs_ir[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    for (int k = 0; k < 3; k++) begin
      new_data();
      run_cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_ov[d] !== 1'b0 || obs_od[d] !== '0 || obs_och[d] !== '0 || obs_ir[d] !== '0) begin
        n_fail++;
        $display("FAIL reset_midstream[dut%0d]: got v=%b d=%h ch=%0d rdy=%b expected all zero (test fail)",
                 d, obs_ov[d], obs_od[d], obs_och[d], obs_ir[d]);
      end
    end
    reset_model();
    drv_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_select();
    apply_reset();
    new_data();
    drv_sel     = 2'd2;
    drv_valid   = 4'b0110;
    drv_data[2] = 64'hDEAD_BEEF_0000_0002;
    drv_ready   = 1'b1;
    #1;
    n_checks++;
    if (if0.in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL sel2_ready: got %b expected 0100 (test fail)", if0.in_ready);
    end
    run_cycle();
    n_checks++;
    if (if0.out_valid !== 1'b1 || if0.out_data !== 64'hDEAD_BEEF_0000_0002 || if0.out_ch !== 2'd2) begin
      n_fail++;
      $display("FAIL sel2_out: got v=%b d=%h ch=%0d expected v=1 d=deadbeef00000002 ch=2 (test fail)",
               if0.out_valid, if0.out_data, if0.out_ch);
    end
    drv_sel   = 2'd1;
    drv_valid = 4'b0001;
    #1;
    n_checks++;
    if (if0.in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL sel1_idle_ready: got %b expected 0000 (test fail)", if0.in_ready);
    end
    run_cycle();
    n_checks++;
    if (if0.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sel1_idle_out: got v=%b expected 0 (test fail)", if0.out_valid);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    drv_valid = '1;
    drv_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      new_data();
      run_cycle();
      n_checks++;
      if (if1.out_valid !== 1'b1 || int'(if1.out_ch) != k % N) begin
        n_fail++;
        $display("FAIL rr_sequence[%0d]: got v=%b ch=%0d expected v=1 ch=%0d (test fail)",
                 k, if1.out_valid, if1.out_ch, k % N);
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    drv_ready = 1'b1;
    new_data();
    drv_valid = 4'b0001;
    run_cycle();
    drv_valid = 4'b1001;
    new_data();
    #1;
    n_checks++;
    if (if1.in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_first_ready: got %b expected 1000 (test fail)", if1.in_ready);
    end
    run_cycle();
    n_checks++;
    if (if1.out_ch !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_first_ch: got %0d expected 3 (test fail)", if1.out_ch);
    end
    new_data();
    #1;
    n_checks++;
    if (if1.in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_second_ready: got %b expected 0001 (test fail)", if1.in_ready);
    end
    run_cycle();
    n_checks++;
    if (if1.out_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_second_ch: got %0d expected 0 (test fail)", if1.out_ch);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held_data [2];
    int               held_ch   [2];
    drv_valid = '1;
    drv_ready = 1'b1;
    drv_sel   = 2'd3;
    new_data();
    run_cycle();
    for (int d = 0; d < 2; d++) begin
      held_data[d] = m_data[d];
      held_ch[d]   = m_ch[d];
    end
    drv_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      new_data();
      #1;
      n_checks++;
      if (if0.in_ready !== '0 || if1.in_ready !== '0) begin
        n_fail++;
        $display("FAIL stall_ready[%0d]: got %b/%b expected 0000/0000 (test fail)",
                 k, if0.in_ready, if1.in_ready);
      end
      run_cycle();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs_ov[d] !== 1'b1 || obs_od[d] !== held_data[d] || int'(obs_och[d]) != held_ch[d]) begin
          n_fail++;
          $display("FAIL stall_hold[dut%0d]: got v=%b ch%0d %h expected v=1 ch%0d %h (test fail)",
                   d, obs_ov[d], obs_och[d], obs_od[d], held_ch[d], held_data[d]);
        end
      end
    end
    // Releasing the stall with inputs pending replaces the held word on the same edge.
    drv_ready = 1'b1;
    new_data();
    run_cycle();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_ov[d] !== 1'b1 || obs_od[d] === held_data[d]) begin
        n_fail++;
        $display("FAIL stall_replace[dut%0d]: got v=%b %h expected v=1 and a new word (test fail)",
                 d, obs_ov[d], obs_od[d]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drv_valid = N'($urandom);
      drv_sel   = SELW'($urandom_range(0, N-1));
      drv_ready = ($urandom_range(0, 3) != 0);
      new_data();
      run_cycle();
    end
  endtask

  task automatic test_drain();
    drv_valid = '0;
    drv_ready = 1'b1;
    for (int k = 0; k < 3; k++) run_cycle();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (sbq[d][i].size() != 0) begin
          n_fail++;
          $display("FAIL drain[dut%0d ch%0d]: got %0d words never delivered expected 0 (test fail)",
                   d, i, sbq[d][i].size());
        end
      end
    end
  endtask

  initial begin
    drv_valid = '0;
    drv_sel   = '0;
    drv_ready = 1'b0;
    for (int i = 0; i < N; i++) drv_data[i] = '0;
    reset_model();
    test_reset();
    test_select();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_random();
    test_drain();
    $display("test complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
